glb_strm_traffic_engine: RTL and testbench

- Synthesizable, parametrised stream stimulus/checker for one GLB tile.
- Generates f2g words on NUM_CH channels and checks returning g2f words against the same deterministic pattern.
- Tracks the f2g/g2f interrupt pulses and enforces a cycle watchdog.
- One instance per tile in the global-buffer bench or an FPGA/emulation harness; it replaces ad-hoc per-tile stream tasks.

---
 rtl/glb_strm_traffic_engine_pkg.sv | 27 ++
 rtl/glb_strm_traffic_engine_pattern_gen.sv | 45 ++++
 rtl/glb_strm_traffic_engine.sv | 199 +++++++++++++++++++
 tb/tb_glb_strm_traffic_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_strm_traffic_engine_pkg.sv
// Shared types and helpers for the GLB stream traffic engine.
package glb_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_IRQ = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef enum logic {
    MODE_INCR = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  localparam logic [15:0] DEFAULT_LFSR_POLY = 16'hB400;

  // Widest pattern word supported by the helper below.
  localparam int unsigned PAT_MAX_W = 64;

  // Per-channel word: pattern value XOR the zero-extended channel index.
  function automatic logic [PAT_MAX_W-1:0] pattern_xor_ch(input logic [PAT_MAX_W-1:0] pat,
                                                          input int unsigned ch);
    return pat ^ PAT_MAX_W'(ch);
  endfunction

endpackage

// File: rtl/glb_strm_traffic_engine_pattern_gen.sv
// Single-channel pattern generator: incrementing or Galois LFSR sequence.
module glb_pattern_gen
  import glb_tb_pkg::*;
#(
  parameter int unsigned           WIDTH = 16,
  parameter logic [WIDTH-1:0]      POLY  = WIDTH'(DEFAULT_LFSR_POLY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_value
);

  mode_e            r_mode;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_step;

  // Next sequence value from the current one.
  always_comb begin
    if (r_mode == MODE_LFSR) begin
      w_step = (r_value >> 1) ^ (r_value[0] ? POLY : '0);
    end else begin
      w_step = r_value + WIDTH'(1);
    end
  end

  // Load seed (zero seed is illegal for the LFSR, so it becomes 1), else step on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= MODE_INCR;
      r_value <= '0;
    end else if (i_load) begin
      r_mode  <= i_mode;
      r_value <= (i_mode == MODE_LFSR && i_seed == '0) ? WIDTH'(1) : i_seed;
    end else if (i_advance) begin
      r_value <= w_step;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/glb_strm_traffic_engine.sv
// Per-tile f2g stream generator and g2f checker with irq tracking and watchdog.
module glb_strm_traffic_engine
  import glb_tb_pkg::*;
#(
  parameter int unsigned              NUM_CH         = 4,
  parameter int unsigned              DATA_WIDTH     = 16,
  parameter int unsigned              LEN_WIDTH      = 16,
  parameter int unsigned              ERR_WIDTH      = 16,
  parameter int unsigned              TIMEOUT_CYCLES = 1000000,
  parameter logic [DATA_WIDTH-1:0]    LFSR_POLY      = DATA_WIDTH'(DEFAULT_LFSR_POLY)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           mode,
  input  logic [DATA_WIDTH-1:0]          seed,
  input  logic [LEN_WIDTH-1:0]           length,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic                           stall,
  output logic [NUM_CH*DATA_WIDTH-1:0]   data_f2g,
  output logic [NUM_CH-1:0]              data_valid_f2g,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data_g2f,
  input  logic [NUM_CH-1:0]              data_valid_g2f,
  input  logic                           strm_f2g_interrupt,
  input  logic                           strm_g2f_interrupt,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [ERR_WIDTH-1:0]           err_count,
  output logic [$clog2(NUM_CH)-1:0]      first_err_ch
);

  localparam int unsigned CH_W      = $clog2(NUM_CH);
  localparam int unsigned POP_W     = $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W     = ERR_WIDTH + POP_W;
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e                         r_state, w_state_next;
  logic [LEN_WIDTH-1:0]           r_len, r_sent;
  logic [LEN_WIDTH-1:0]           r_rcv [NUM_CH];
  logic [NUM_CH-1:0]              r_ch_en;
  logic [31:0]                    r_wdog;
  logic                           r_irq_f2g, r_irq_g2f;
  logic [ERR_WIDTH-1:0]           r_err_count;
  logic [CH_W-1:0]                r_first_err_ch;
  logic                           r_pass, r_timeout;
  logic [NUM_CH-1:0]              r_valid_f2g;
  logic [NUM_CH*DATA_WIDTH-1:0]   r_data_f2g;

  logic                           w_accept, w_active, w_issue, w_rx_done, w_wdog_hit, w_to_done;
  logic [DATA_WIDTH-1:0]          w_f2g_pat;
  logic [DATA_WIDTH-1:0]          w_exp_pat [NUM_CH];
  logic [NUM_CH-1:0]              w_rx_take, w_rx_err, w_f2g_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]   w_f2g_data;
  logic [POP_W-1:0]               w_err_pop;
  logic [CH_W-1:0]                w_err_lowest;
  logic                           w_err_found;
  logic [SUM_W-1:0]               w_err_sum;
  logic [ERR_WIDTH-1:0]           w_err_next;

  assign w_accept   = start && (r_state == ST_IDLE);
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_WAIT_IRQ);
  assign w_issue    = (r_state == ST_RUN) && (r_sent < r_len) && !stall;
  assign w_wdog_hit = w_active && (r_wdog >= WDOG_LAST);
  assign w_to_done  = w_active && (w_state_next == ST_DONE);

  glb_pattern_gen #(.WIDTH(DATA_WIDTH), .POLY(LFSR_POLY)) u_f2g_gen (
    .clk(clk), .reset(reset), .i_load(w_accept), .i_mode(mode_e'(mode)),
    .i_seed(seed), .i_advance(w_issue), .o_value(w_f2g_pat)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_exp
    glb_pattern_gen #(.WIDTH(DATA_WIDTH), .POLY(LFSR_POLY)) u_exp_gen (
      .clk(clk), .reset(reset), .i_load(w_accept), .i_mode(mode_e'(mode)),
      .i_seed(seed), .i_advance(w_rx_take[g]), .o_value(w_exp_pat[g])
    );
  end

  // Next f2g beat: enabled channels carry pattern XOR channel, others stay zero.
  always_comb begin
    w_f2g_valid = '0;
    w_f2g_data  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_issue && r_ch_en[c]) begin
        w_f2g_valid[c] = 1'b1;
        w_f2g_data[c*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(pattern_xor_ch(PAT_MAX_W'(w_f2g_pat), c));
      end
    end
  end

  // Classify returning words: in-window words advance the expectation, excess or wrong words are errors.
  always_comb begin
    w_rx_take = '0;
    w_rx_err  = '0;
    w_rx_done = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (r_ch_en[c] && r_rcv[c] != r_len) w_rx_done = 1'b0;
      if (w_active && data_valid_g2f[c]) begin
        if (!r_ch_en[c] || r_rcv[c] == r_len) begin
          w_rx_err[c] = 1'b1;
        end else begin
          w_rx_take[c] = 1'b1;
          if (data_g2f[c*DATA_WIDTH +: DATA_WIDTH] !=
              DATA_WIDTH'(pattern_xor_ch(PAT_MAX_W'(w_exp_pat[c]), c)))
            w_rx_err[c] = 1'b1;
        end
      end
    end
  end

  // Per-cycle error popcount, lowest erroring channel and saturating total.
  always_comb begin
    w_err_pop    = '0;
    w_err_lowest = '0;
    w_err_found  = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_rx_err[c]) begin
        w_err_pop = w_err_pop + POP_W'(1);
        if (!w_err_found) begin
          w_err_lowest = CH_W'(c);
          w_err_found  = 1'b1;
        end
      end
    end
    w_err_sum  = SUM_W'(r_err_count) + SUM_W'(w_err_pop);
    w_err_next = (w_err_sum[SUM_W-1:ERR_WIDTH] != '0) ? '1 : w_err_sum[ERR_WIDTH-1:0];
  end

  // Run sequencing; the watchdog overrides normal completion.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_state_next = ST_RUN;
      ST_RUN:      if (w_wdog_hit) w_state_next = ST_DONE;
                   else if (r_sent == r_len && w_rx_done) w_state_next = ST_WAIT_IRQ;
      ST_WAIT_IRQ: if (w_wdog_hit || (r_irq_f2g && r_irq_g2f)) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Run bookkeeping: config capture, counters, irq flags, error tracking and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len <= '0; r_sent <= '0; r_ch_en <= '0; r_wdog <= '0;
      r_irq_f2g <= 1'b0; r_irq_g2f <= 1'b0;
      r_err_count <= '0; r_first_err_ch <= '0; r_pass <= 1'b0; r_timeout <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) r_rcv[c] <= '0;
    end else if (w_accept) begin
      r_len <= length; r_sent <= '0; r_ch_en <= ch_en; r_wdog <= '0;
      r_irq_f2g <= 1'b0; r_irq_g2f <= 1'b0;
      r_err_count <= '0; r_first_err_ch <= '0; r_pass <= 1'b0; r_timeout <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) r_rcv[c] <= '0;
    end else if (w_active) begin
      r_wdog <= r_wdog + 32'd1;
      if (strm_f2g_interrupt) r_irq_f2g <= 1'b1;
      if (strm_g2f_interrupt) r_irq_g2f <= 1'b1;
      if (w_issue) r_sent <= r_sent + LEN_WIDTH'(1);
      for (int unsigned c = 0; c < NUM_CH; c++)
        if (w_rx_take[c]) r_rcv[c] <= r_rcv[c] + LEN_WIDTH'(1);
      r_err_count <= w_err_next;
      if (r_err_count == '0 && w_rx_err != '0) r_first_err_ch <= w_err_lowest;
      // Result is captured on the DONE entry edge so pass is valid alongside done.
      if (w_to_done) begin
        r_timeout <= w_wdog_hit;
        r_pass    <= (w_err_next == '0) && !w_wdog_hit;
      end
    end
  end

  // Registered f2g output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_f2g <= '0;
      r_data_f2g  <= '0;
    end else begin
      r_valid_f2g <= w_f2g_valid;
      r_data_f2g  <= w_f2g_data;
    end
  end

  assign data_f2g       = r_data_f2g;
  assign data_valid_f2g = r_valid_f2g;
  assign busy           = w_active;
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_count      = r_err_count;
  assign first_err_ch   = r_first_err_ch;

endmodule

// File: tb/tb_glb_strm_traffic_engine.sv
// Randomised self-checking bench for glb_strm_traffic_engine with a word-list reference model.
module tb_glb_strm_traffic_engine;

  logic        clk, reset, start, mode, stall;
  logic [15:0] seed, length;
  logic [3:0]  ch_en, data_valid_f2g, data_valid_g2f, extra_valid;
  logic [63:0] data_f2g, data_g2f, inj_xor_v;
  logic        strm_f2g_interrupt, strm_g2f_interrupt;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [1:0]  first_err_ch;

  int          n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, tb_vcount = 0;
  int          inj_at;

  // Reference model state for the current run.
  int unsigned m_len, m_err, m_first;
  logic [3:0]  m_en;
  logic [15:0] exp_w [4][32];
  logic [15:0] obs   [4][32];
  int unsigned f2g_cnt [4];
  int unsigned m_rcv   [4];
  int unsigned n_done = 0, done_cyc = 0;
  logic        s_pass, s_to;
  logic [15:0] s_err;
  logic [1:0]  s_first;

  glb_strm_traffic_engine #(
    .NUM_CH(4), .DATA_WIDTH(16), .LEN_WIDTH(16), .ERR_WIDTH(16),
    .TIMEOUT_CYCLES(100), .LFSR_POLY(16'hB400)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .length(length), .ch_en(ch_en), .stall(stall),
    .data_f2g(data_f2g), .data_valid_f2g(data_valid_f2g),
    .data_g2f(data_g2f), .data_valid_g2f(data_valid_g2f),
    .strm_f2g_interrupt(strm_f2g_interrupt), .strm_g2f_interrupt(strm_g2f_interrupt),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_ch(first_err_ch)
  );

  // Loopback with optional corruption of one beat and extra unsolicited valids.
  assign data_valid_g2f = data_valid_f2g | extra_valid;
  assign data_g2f       = data_f2g ^ ((int'(tb_vcount) == inj_at) ? inj_xor_v : 64'h0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_valid_f2g != 4'b0) tb_vcount <= tb_vcount + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pattern_at(input logic md, input logic [15:0] sd, input int unsigned k);
    logic [15:0] v;
    if (md) begin
      v = (sd == 16'h0) ? 16'h1 : sd;
      for (int unsigned i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    end else begin
      v = sd + 16'(k);
    end
    return v;
  endfunction

  function automatic bit all_complete();
    for (int unsigned c = 0; c < 4; c++)
      if (m_en[c] && (f2g_cnt[c] != m_len || m_rcv[c] != m_len)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_setup(input logic md, input logic [15:0] sd, input int unsigned len, input logic [3:0] en);
    m_len = len; m_en = en; m_err = 0; m_first = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      f2g_cnt[c] = 0; m_rcv[c] = 0;
      for (int unsigned k = 0; k < 32; k++) exp_w[c][k] = pattern_at(md, sd, k) ^ 16'(c);
    end
  endtask

  // Observe outputs mid-cycle: f2g words against the list, g2f words through the checker model.
  always @(negedge clk) begin
    int unsigned cyc_err;
    int          lowest;
    if (done === 1'b1) begin
      n_done++; done_cyc = cyc;
      s_pass = pass; s_to = timeout; s_err = err_count; s_first = first_err_ch;
    end
    if (!$isunknown(data_valid_f2g) && data_valid_f2g != 4'b0) begin
      check("f2g_mask", 64'(data_valid_f2g), 64'(m_en));
      for (int unsigned c = 0; c < 4; c++) begin
        if (data_valid_f2g[c]) begin
          if (f2g_cnt[c] < m_len)
            check($sformatf("f2g_word ch%0d k%0d", c, f2g_cnt[c]), 64'(data_f2g[c*16 +: 16]),
                  64'(exp_w[c][f2g_cnt[c]]));
          if (f2g_cnt[c] < 32) obs[c][f2g_cnt[c]] = data_f2g[c*16 +: 16];
          f2g_cnt[c]++;
        end else begin
          check($sformatf("f2g_idle_data ch%0d", c), 64'(data_f2g[c*16 +: 16]), 64'h0);
        end
      end
    end
    if (busy === 1'b1) begin
      cyc_err = 0; lowest = -1;
      for (int unsigned c = 0; c < 4; c++) begin
        if (data_valid_g2f[c] === 1'b1) begin
          bit bad;
          bad = 1'b0;
          if (!m_en[c] || m_rcv[c] == m_len) bad = 1'b1;
          else begin
            if (data_g2f[c*16 +: 16] !== exp_w[c][m_rcv[c]]) bad = 1'b1;
            m_rcv[c]++;
          end
          if (bad) begin
            cyc_err++;
            if (lowest < 0) lowest = int'(c);
          end
        end
      end
      if (cyc_err != 0) begin
        if (m_err == 0) m_first = int'(lowest);
        m_err = (m_err + cyc_err > 65535) ? 65535 : m_err + cyc_err;
      end
    end
  end

  task automatic do_run(input string name, input logic md, input logic [15:0] sd, input int unsigned len,
                        input logic [3:0] en, input int unsigned stall_pct, input int unsigned stall_at,
                        input int unsigned stall_n, input bit extra, input bit hold_g2f, input bit exp_to,
                        input int inj_k, input logic [63:0] inj_x);
    int unsigned done0, acc;
    bit fired, got, exp_pass;
    model_setup(md, sd, len, en);
    inj_x = inj_x; inj_xor_v = inj_x;
    inj_at = (inj_k >= 0) ? int'(tb_vcount) + inj_k : -1;
    done0 = n_done;
    mode = md; seed = sd; length = 16'(len); ch_en = en; start = 1'b1;
    tick();
    start = 1'b0; acc = cyc;
    check({name, "_busy_start"}, 64'(busy), 64'h1);
    fired = 1'b0; got = 1'b0;
    for (int i = 0; i < 150 && !got; i++) begin
      stall = (stall_n > 0 && i >= int'(stall_at) && i < int'(stall_at + stall_n)) ||
              ($urandom_range(99, 0) < stall_pct);
      extra_valid = extra ? (4'($urandom) & 4'($urandom) & 4'($urandom)) : 4'b0;
      strm_f2g_interrupt = 1'b0; strm_g2f_interrupt = 1'b0;
      if (!fired && all_complete()) begin
        strm_f2g_interrupt = 1'b1;
        strm_g2f_interrupt = !hold_g2f;
        fired = 1'b1;
      end
      tick();
      if (n_done != done0) got = 1'b1;
    end
    stall = 1'b0; extra_valid = 4'b0; strm_f2g_interrupt = 1'b0; strm_g2f_interrupt = 1'b0;
    exp_pass = (m_err == 0) && !exp_to;
    check({name, "_done_pulses"}, 64'(n_done - done0), 64'd1);
    check({name, "_pass"}, 64'(s_pass), 64'(exp_pass));
    check({name, "_timeout"}, 64'(s_to), 64'(exp_to));
    check({name, "_err_count"}, 64'(s_err), 64'(m_err));
    check({name, "_first_err_ch"}, 64'(s_first), 64'(m_first));
    for (int unsigned c = 0; c < 4; c++)
      check($sformatf("%s_f2g_count ch%0d", name, c), 64'(f2g_cnt[c]), en[c] ? 64'(len) : 64'h0);
    if (exp_to) check({name, "_wdog_cycles"}, 64'(done_cyc - acc), 64'd100);
    check({name, "_busy_after"}, 64'(busy), 64'h0);
    check({name, "_done_after"}, 64'(done), 64'h0);
    check({name, "_pass_held"}, 64'(pass), 64'(exp_pass));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no finish, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; length = '0; ch_en = '0; stall = 1'b0;
    strm_f2g_interrupt = 1'b0; strm_g2f_interrupt = 1'b0; extra_valid = '0;
    inj_at = -1; inj_xor_v = '0;
    model_setup(1'b0, 16'h0, 0, 4'h0);
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_pass", 64'(pass), 64'h0);
    check("rst_timeout", 64'(timeout), 64'h0);
    check("rst_err", 64'(err_count), 64'h0);
    check("rst_first", 64'(first_err_ch), 64'h0);
    check("rst_valid", 64'(data_valid_f2g), 64'h0);
    check("rst_data", data_f2g, 64'h0);
    tick();

    do_run("incr", 1'b0, 16'h0010, 8, 4'b1111, 0, 0, 0, 1'b0, 1'b0, 1'b0, -1, 64'h0);
    check("incr_ch2_w3", 64'(obs[2][3]), 64'h0011);

    do_run("lfsr", 1'b1, 16'h0000, 4, 4'b1111, 0, 0, 0, 1'b0, 1'b0, 1'b0, -1, 64'h0);
    check("lfsr_ch0_w0", 64'(obs[0][0]), 64'h0001);

    do_run("inject", 1'b0, 16'h0010, 8, 4'b1111, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2, 64'h0100_0000_0100_0000);
    check("inject_err2", 64'(s_err), 64'd2);
    check("inject_first1", 64'(s_first), 64'd1);

    do_run("stall", 1'b0, 16'($urandom), 6, 4'b1011, 0, 3, 5, 1'b0, 1'b0, 1'b0, -1, 64'h0);

    strm_f2g_interrupt = 1'b1; strm_g2f_interrupt = 1'b1;
    tick();
    strm_f2g_interrupt = 1'b0; strm_g2f_interrupt = 1'b0;
    do_run("wdog", 1'b0, 16'h1234, 4, 4'b1111, 0, 0, 0, 1'b0, 1'b1, 1'b1, -1, 64'h0);

    // Abort a run with reset three cycles in; no done may follow.
    begin
      int unsigned d0;
      model_setup(1'b0, 16'h0040, 8, 4'b1111);
      mode = 1'b0; seed = 16'h0040; length = 16'd8; ch_en = 4'b1111; start = 1'b1;
      tick();
      start = 1'b0; d0 = n_done;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_valid", 64'(data_valid_f2g), 64'h0);
      check("abort_err", 64'(err_count), 64'h0);
      repeat (20) tick();
      check("abort_no_done", 64'(n_done - d0), 64'h0);
    end
    do_run("len0", 1'b0, 16'h0005, 0, 4'b1111, 0, 0, 0, 1'b0, 1'b0, 1'b0, -1, 64'h0);

    for (int r = 0; r < 8; r++)
      do_run($sformatf("rnd%0d", r), 1'($urandom), 16'($urandom), $urandom_range(12, 0), 4'($urandom),
             20, 0, 0, r[0], 1'b0, 1'b0, -1, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
